// File: rtl/lsu_mem_sequencer.sv
// Load/store sequencer: aligns, lane-encodes and issues one memory access per transaction,
// then returns extended load data with a misalignment/timeout error flag.
module lsu_mem_sequencer #(
    parameter int unsigned MAX_WAIT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        mem_req,
    input  logic        mem_gnt,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_we,
    output logic [31:0] mem_wdata,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_data,
    output logic        rsp_err,
    output logic        stall
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        WAIT_R = 2'd2,
        RESP   = 2'd3
    } state_t;

    localparam logic [7:0] CNT_LAST = 8'(MAX_WAIT - 1);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        we_q;
    logic [1:0]  size_q;
    logic        uns_q;
    logic [31:0] addr_q;
    logic [3:0]  lane_we_q;
    logic [31:0] lane_wdata_q;
    logic [31:0] rsp_data_q, rsp_data_d;
    logic        rsp_err_q, rsp_err_d;
    logic        capture_en;

    logic        misaligned;
    logic [3:0]  lane_we_d;
    logic [31:0] lane_wdata_d;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_fmt;

    assign misaligned = (req_size == 2'd3)
                      | ((req_size == 2'd1) & req_addr[0])
                      | ((req_size == 2'd2) & (req_addr[1:0] != 2'b00));

    // Lane encoding is done from the live request so it can be registered on the accept edge.
    always_comb begin
        lane_we_d    = 4'b0000;
        lane_wdata_d = req_wdata;
        case (req_size)
            2'd0: begin
                lane_we_d    = 4'b0001 << req_addr[1:0];
                lane_wdata_d = {4{req_wdata[7:0]}};
            end
            2'd1: begin
                lane_we_d    = req_addr[1] ? 4'b1100 : 4'b0011;
                lane_wdata_d = {2{req_wdata[15:0]}};
            end
            default: begin
                lane_we_d    = 4'b1111;
                lane_wdata_d = req_wdata;
            end
        endcase
        if (!req_we) begin
            lane_we_d = 4'b0000;
        end
    end

    always_comb begin
        ld_byte = 8'h00;
        case (addr_q[1:0])
            2'd0:    ld_byte = mem_rdata[7:0];
            2'd1:    ld_byte = mem_rdata[15:8];
            2'd2:    ld_byte = mem_rdata[23:16];
            default: ld_byte = mem_rdata[31:24];
        endcase
        ld_half = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (size_q)
            2'd0:    ld_fmt = uns_q ? {24'h0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
            2'd1:    ld_fmt = uns_q ? {16'h0, ld_half} : {{16{ld_half[15]}}, ld_half};
            default: ld_fmt = mem_rdata;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;
        capture_en = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    capture_en = 1'b1;
                    cnt_d      = 8'd0;
                    rsp_data_d = 32'h0;
                    rsp_err_d  = misaligned;
                    state_d    = misaligned ? RESP : REQ;
                end
            end
            REQ: begin
                // A grant in the final counted cycle still completes normally.
                if (mem_gnt) begin
                    cnt_d   = 8'd0;
                    state_d = we_q ? RESP : WAIT_R;
                end else if (cnt_q == CNT_LAST) begin
                    rsp_err_d = 1'b1;
                    state_d   = RESP;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            WAIT_R: begin
                if (mem_rvalid) begin
                    rsp_data_d = ld_fmt;
                    state_d    = RESP;
                end else if (cnt_q == CNT_LAST) begin
                    rsp_err_d = 1'b1;
                    state_d   = RESP;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= 8'd0;
            we_q         <= 1'b0;
            size_q       <= 2'd0;
            uns_q        <= 1'b0;
            addr_q       <= 32'h0;
            lane_we_q    <= 4'h0;
            lane_wdata_q <= 32'h0;
            rsp_data_q   <= 32'h0;
            rsp_err_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
            if (capture_en) begin
                we_q         <= req_we;
                size_q       <= req_size;
                uns_q        <= req_unsigned;
                addr_q       <= req_addr;
                lane_we_q    <= lane_we_d;
                lane_wdata_q <= lane_wdata_d;
            end
        end
    end

    // Memory-side outputs are only driven while a request is outstanding.
    assign req_ready = (state_q == IDLE);
    assign mem_req   = (state_q == REQ);
    assign mem_addr  = mem_req ? {addr_q[31:2], 2'b00} : 32'h0;
    assign mem_we    = mem_req ? lane_we_q : 4'h0;
    assign mem_wdata = mem_req ? lane_wdata_q : 32'h0;
    assign rsp_valid = (state_q == RESP);
    assign rsp_data  = rsp_valid ? rsp_data_q : 32'h0;
    assign rsp_err   = rsp_valid & rsp_err_q;
    assign stall     = ((state_q == IDLE) & req_valid) | (state_q == REQ) | (state_q == WAIT_R);

endmodule

// File: tb/tb_lsu_mem_sequencer.sv
// Directed bench for lsu_mem_sequencer: expected responses and memory requests are queued by the
// stimulus and checked by an independent negedge monitor.
module tb_lsu_mem_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'd0;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        mem_req;
    logic        mem_gnt = 1'b0;
    logic [31:0] mem_addr;
    logic [3:0]  mem_we;
    logic [31:0] mem_wdata;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = 32'h0;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic        stall;

    lsu_mem_sequencer #(.MAX_WAIT(16)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_size(req_size),
        .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
        .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_addr(mem_addr), .mem_we(mem_we),
        .mem_wdata(mem_wdata), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err), .stall(stall)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          lat;
    } rsp_exp_t;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  we;
        logic [31:0] wdata;
        logic        chk_wdata;
    } mem_exp_t;

    rsp_exp_t rsp_q[$];
    mem_exp_t mem_q[$];
    int       acc_q[$];
    mem_exp_t cur;

    int   n_cmp = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   run_len = 0;
    int   last_run = 0;
    int   rsp_cnt = 0;
    int   acc_cnt = 0;
    logic prev_req = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, want 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: samples on the falling edge, away from the DUT's active edge.
    always @(negedge clk) begin
        if (reset) begin
            acc_q.delete();
            run_len  = 0;
            prev_req = 1'b0;
        end else begin
            if (req_valid && req_ready) begin
                acc_q.push_back(cyc);
                acc_cnt++;
                check("stall_on_accept", {31'h0, stall}, 32'h1);
            end
            if (mem_req) begin
                check("stall_in_req", {31'h0, stall}, 32'h1);
                if (!prev_req) begin
                    if (mem_q.size() == 0) begin
                        check("unexpected_mem_req", 32'h1, 32'h0);
                        cur = '{32'h0, 4'h0, 32'h0, 1'b0};
                    end else begin
                        cur = mem_q.pop_front();
                    end
                end
                check("mem_addr", mem_addr, cur.addr);
                check("mem_we", {28'h0, mem_we}, {28'h0, cur.we});
                if (cur.chk_wdata) check("mem_wdata", mem_wdata, cur.wdata);
                run_len++;
            end else if (prev_req) begin
                last_run = run_len;
                run_len  = 0;
            end
            prev_req = mem_req;
            if (rsp_valid) begin
                rsp_exp_t e;
                int       a;
                rsp_cnt++;
                check("stall_in_resp", {31'h0, stall}, 32'h0);
                check("ready_in_resp", {31'h0, req_ready}, 32'h0);
                if (rsp_q.size() == 0 || acc_q.size() == 0) begin
                    check("unexpected_rsp", 32'h1, 32'h0);
                end else begin
                    e = rsp_q.pop_front();
                    a = acc_q.pop_front();
                    check("rsp_data", rsp_data, e.data);
                    check("rsp_err", {31'h0, rsp_err}, {31'h0, e.err});
                    check("rsp_latency", 32'(cyc - a), 32'(e.lat));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // gd/rvd: idle cycles before gnt/rvalid; negative means the event never comes.
    task automatic do_op(input logic we, input logic [1:0] sz, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input int gd, input int rvd, input logic [31:0] rdata,
                         input logic [31:0] edata, input logic eerr, input int elat,
                         input logic mem_on, input logic [3:0] ewe, input logic [31:0] ewd);
        rsp_exp_t r;
        mem_exp_t m;
        r = '{edata, eerr, elat};
        rsp_q.push_back(r);
        if (mem_on) begin
            m = '{{addr[31:2], 2'b00}, ewe, ewd, we};
            mem_q.push_back(m);
        end
        tick();
        req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
        req_addr = addr; req_wdata = wdata;
        tick();
        req_valid = 1'b0;
        if (mem_on && gd >= 0) begin
            repeat (gd) tick();
            mem_gnt = 1'b1;
            tick();
            mem_gnt = 1'b0;
            if (!we && rvd >= 0) begin
                repeat (rvd) tick();
                mem_rvalid = 1'b1;
                mem_rdata  = rdata;
                tick();
                mem_rvalid = 1'b0;
                mem_rdata  = 32'h0;
            end
        end
        for (int i = 0; i < 64 && !rsp_valid; i++) tick();
        if (!rsp_valid) check("rsp_wait_timeout", 32'h0, 32'h1);
        @(negedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, want finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        int base_rsp;
        int base_acc;

        repeat (3) tick();
        check("rst_mem_req", {31'h0, mem_req}, 32'h0);
        check("rst_mem_we", {28'h0, mem_we}, 32'h0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        check("rst_stall", {31'h0, stall}, 32'h0);
        reset = 1'b0;
        tick();
        check("ready_after_reset", {31'h0, req_ready}, 32'h1);

        // LB signed 0x103, byte 3 of 0x80FF1234 = 0x80.
        do_op(1'b0, 2'd0, 1'b0, 32'h0000_0103, 32'h0, 0, 0, 32'h80FF_1234,
              32'hFFFF_FF80, 1'b0, 3, 1'b1, 4'b0000, 32'h0);
        // SH 0x202 with grant delayed 3 cycles.
        do_op(1'b1, 2'd1, 1'b0, 32'h0000_0202, 32'hDEAD_BEEF, 3, 0, 32'h0,
              32'h0, 1'b0, 5, 1'b1, 4'b1100, 32'hBEEF_BEEF);
        check("sh_req_cycles", 32'(last_run), 32'd4);
        // LW 0x6 misaligned, then LHU 0x6 upper half.
        do_op(1'b0, 2'd2, 1'b0, 32'h0000_0006, 32'h0, -1, -1, 32'h0,
              32'h0, 1'b1, 1, 1'b0, 4'h0, 32'h0);
        do_op(1'b0, 2'd1, 1'b1, 32'h0000_0006, 32'h0, 0, 0, 32'h8001_5A5A,
              32'h0000_8001, 1'b0, 3, 1'b1, 4'b0000, 32'h0);
        // LH signed 0x0, rvalid 2 cycles late.
        do_op(1'b0, 2'd1, 1'b0, 32'h0000_0000, 32'h0, 0, 2, 32'h1234_F00D,
              32'hFFFF_F00D, 1'b0, 5, 1'b1, 4'b0000, 32'h0);
        // LBU 0x1, grant one cycle late.
        do_op(1'b0, 2'd0, 1'b1, 32'h0000_0001, 32'h0, 1, 0, 32'h0000_F200,
              32'h0000_00F2, 1'b0, 4, 1'b1, 4'b0000, 32'h0);
        // size=3 store and SH at odd address both rejected.
        do_op(1'b1, 2'd3, 1'b0, 32'h0000_0000, 32'h1111_2222, -1, -1, 32'h0,
              32'h0, 1'b1, 1, 1'b0, 4'h0, 32'h0);
        do_op(1'b1, 2'd1, 1'b0, 32'h0000_0001, 32'h1111_2222, -1, -1, 32'h0,
              32'h0, 1'b1, 1, 1'b0, 4'h0, 32'h0);
        // Grant never comes: 16 cycles of mem_req then error.
        do_op(1'b0, 2'd2, 1'b0, 32'h0000_0040, 32'h0, -1, -1, 32'h0,
              32'h0, 1'b1, 17, 1'b1, 4'b0000, 32'h0);
        check("timeout_req_cycles", 32'(last_run), 32'd16);
        tick();
        check("ready_after_timeout", {31'h0, req_ready}, 32'h1);
        // Grant on the 16th REQ cycle beats the timeout.
        do_op(1'b1, 2'd2, 1'b0, 32'h0000_0044, 32'h1234_5678, 15, 0, 32'h0,
              32'h0, 1'b0, 17, 1'b1, 4'b1111, 32'h1234_5678);
        check("late_gnt_req_cycles", 32'(last_run), 32'd16);
        // rvalid never comes, then rvalid on the 16th WAIT_R cycle.
        do_op(1'b0, 2'd2, 1'b0, 32'h0000_0048, 32'h0, 0, -1, 32'h0,
              32'h0, 1'b1, 18, 1'b1, 4'b0000, 32'h0);
        do_op(1'b0, 2'd2, 1'b0, 32'h0000_004C, 32'h0, 0, 15, 32'hCAFE_0123,
              32'hCAFE_0123, 1'b0, 18, 1'b1, 4'b0000, 32'h0);

        // Reset while waiting for read data; the late rvalid must be ignored.
        begin
            mem_exp_t m;
            m = '{32'h0000_0010, 4'b0000, 32'h0, 1'b0};
            mem_q.push_back(m);
        end
        base_rsp = rsp_cnt;
        tick();
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_addr = 32'h0000_0010;
        tick();
        req_valid = 1'b0; mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        check("wait_r_no_req", {31'h0, mem_req}, 32'h0);
        reset = 1'b1;
        #1;
        check("mid_rst_stall", {31'h0, stall}, 32'h0);
        tick();
        reset = 1'b0;
        tick();
        mem_rvalid = 1'b1; mem_rdata = 32'hFFFF_FFFF;
        tick();
        mem_rvalid = 1'b0; mem_rdata = 32'h0;
        tick();
        check("post_rst_rsp_cnt", 32'(rsp_cnt - base_rsp), 32'd0);
        check("post_rst_ready", {31'h0, req_ready}, 32'h1);
        check("post_rst_mem_req", {31'h0, mem_req}, 32'h0);
        check("post_rst_rsp_data", rsp_data, 32'h0);
        do_op(1'b1, 2'd0, 1'b0, 32'h0000_0001, 32'h0000_00AB, 0, 0, 32'h0,
              32'h0, 1'b0, 2, 1'b1, 4'b0010, 32'hABAB_ABAB);

        // Four back-to-back stores with req_valid held and grant always high.
        begin
            logic [1:0]  sz_t [4] = '{2'd2, 2'd0, 2'd1, 2'd0};
            logic [31:0] ad_t [4] = '{32'h300, 32'h302, 32'h306, 32'h307};
            logic [31:0] wd_t [4] = '{32'h1122_3344, 32'h55, 32'hCAFE, 32'h9A};
            logic [3:0]  we_t [4] = '{4'b1111, 4'b0100, 4'b1100, 4'b1000};
            logic [31:0] ew_t [4] = '{32'h1122_3344, 32'h5555_5555, 32'hCAFE_CAFE, 32'h9A9A_9A9A};
            for (int i = 0; i < 4; i++) begin
                rsp_exp_t r;
                mem_exp_t m;
                r = '{32'h0, 1'b0, 2};
                m = '{{ad_t[i][31:2], 2'b00}, we_t[i], ew_t[i], 1'b1};
                rsp_q.push_back(r);
                mem_q.push_back(m);
            end
            tick();
            base_rsp = rsp_cnt;
            base_acc = acc_cnt;
            mem_gnt = 1'b1;
            for (int i = 0; i < 4; i++) begin
                req_valid = 1'b1; req_we = 1'b1; req_size = sz_t[i]; req_unsigned = 1'b0;
                req_addr = ad_t[i]; req_wdata = wd_t[i];
                for (int k = 0; k < 8 && !req_ready; k++) tick();
                tick();
            end
            req_valid = 1'b0;
            repeat (4) tick();
            mem_gnt = 1'b0;
            check("b2b_rsp_count", 32'(rsp_cnt - base_rsp), 32'd4);
            check("b2b_acc_count", 32'(acc_cnt - base_acc), 32'd4);
        end

        check("rsp_queue_drained", 32'(rsp_q.size()), 32'd0);
        check("mem_queue_drained", 32'(mem_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/lsu_mem_sequencer.md
Name: lsu_mem_sequencer

Overview:
- Multi-cycle controller between the execute-stage load/store unit and the data-memory port.
- Accepts one load or store per transaction and checks alignment.
- Generates byte-lane enables and replicated write data, then runs a req/gnt/rvalid handshake with memory.
- Returns sign- or zero-extended load data, and stalls the pipeline until the access completes, errors or times out.

Parameters:
- MAX_WAIT, 16, maximum cycles spent in REQ (waiting for mem_gnt) or in WAIT_R (waiting for mem_rvalid) before a timeout error; legal range 2..255.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  execute stage presents a memory operation.
- req_ready  out  1  sequencer can accept; high only in IDLE.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  0 = byte, 1 = half, 2 = word; 3 is treated as a misaligned error.
- req_unsigned  in  1  load zero-extends (LBU/LHU) when 1.
- req_addr  in  32  byte address (base + offset already summed).
- req_wdata  in  32  store data, LSB-aligned.
- mem_req  out  1  memory request, held until mem_gnt.
- mem_gnt  in  1  memory accepts the request this cycle.
- mem_addr  out  32  word-aligned address, {addr[31:2],2'b00}.
- mem_we  out  4  byte-lane write enables; 0000 for loads.
- mem_wdata  out  32  lane-replicated store data.
- mem_rvalid  in  1  load data valid.
- mem_rdata  in  32  raw load word.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_data  out  32  extended load data; 0 for stores and on error.
- rsp_err  out  1  misaligned or timeout; valid with rsp_valid.
- stall  out  1  freeze the pipeline.

Behaviour:
- States: IDLE, REQ, WAIT_R, RESP.
- Reset (asynchronous, any state): go to IDLE, clear the counter and all captured registers.
  - Outputs during and after reset: mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, rsp_valid=0, rsp_err=0, rsp_data=0, stall=0.
  - req_ready=1 once reset deasserts (IDLE).
  - A reset mid-transaction drops mem_req immediately; a late mem_rvalid/mem_gnt arriving in IDLE is ignored.
- Accept happens in IDLE when req_valid=1. All request fields are registered on that edge.
  - Misaligned request (half with addr[0]=1, word with addr[1:0]!=0, or size=3): go to RESP with err=1. No memory access is issued.
  - Otherwise: go to REQ.
- REQ:
  - mem_req=1; mem_addr, mem_we and mem_wdata are held stable every cycle until the gnt.
  - On mem_gnt: a store goes to RESP; a load goes to WAIT_R.
- WAIT_R:
  - mem_req=0.
  - mem_rvalid is sampled only in this state. It must arrive at least 1 cycle after the gnt; rvalid in the gnt cycle is ignored.
  - On mem_rvalid: register the formatted data and go to RESP.
- Timeout:
  - The counter clears on entry to REQ and to WAIT_R, and increments each cycle without the awaited event.
  - When count==MAX_WAIT-1 and the event is still absent, go to RESP with err=1. This gives exactly MAX_WAIT cycles in the state.
  - The event wins over a timeout in the same cycle.
- RESP: rsp_valid=1 for exactly one cycle, req_ready=0, then IDLE. Back-to-back accepts are therefore possible every other cycle at best.
- stall: high when (IDLE & req_valid) or the state is REQ or WAIT_R; low in RESP and idle IDLE.
- Store lanes (k = addr[1:0]):
  - Byte: mem_we = 4'b0001<<k, mem_wdata = {4{wdata[7:0]}}.
  - Half: mem_we = 4'b0011<<(2*addr[1]), mem_wdata = {2{wdata[15:0]}}.
  - Word: mem_we = 1111, mem_wdata = wdata.
- Load format:
  - Byte: rdata[8k+7:8k], extended to 32 bits.
  - Half: rdata[16*addr[1]+15 : 16*addr[1]], extended to 32 bits.
  - Word: unmodified.
  - Extension is sign unless req_unsigned=1.
- Latency, counted in cycles after the accept edge:
  - Load, with zero-wait gnt and rvalid one cycle later: rsp_valid 3 cycles after accept.
  - Store, zero-wait gnt: rsp_valid 2 cycles after accept.
  - Misaligned: rsp_valid 1 cycle after accept.

Test Plan:
- Reset, then load byte signed at addr 0x103; gnt in the first REQ cycle, rvalid next cycle with rdata=0x80FF_1234 → mem_addr=0x100, mem_we=0000; rsp_valid at accept+3, rsp_data=0xFFFF_FF80, err=0.
- Store half at addr 0x202, wdata=0xDEAD_BEEF, gnt delayed 3 cycles → mem_req held 4 cycles with stable outputs, mem_we=1100, mem_wdata=0xBEEF_BEEF; rsp_valid 1 cycle after gnt; stall high throughout REQ.
- Load word at 0x6 → no mem_req; rsp_valid at accept+1 with rsp_err=1, rsp_data=0. Repeat with LHU at 0x6 and rdata=0x8001_xxxx → rsp_data=0x0000_8001, err=0.
- MAX_WAIT=16 with mem_gnt never asserted → mem_req high exactly 16 cycles, then rsp_valid with err=1, then IDLE with req_ready=1. Repeat with gnt arriving on the 16th cycle → normal completion, no error.
- Assert reset during WAIT_R, then pulse mem_rvalid after release → no rsp_valid; all outputs 0 and req_ready=1; a following SB at 0x1 with wdata=0xAB gives mem_we=0010, mem_wdata=0xABAB_ABAB.
- Hold req_valid high for 4 back-to-back stores with zero-wait gnt → accepts only in IDLE; exactly 4 rsp_valid pulses, none lost or duplicated.
